// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_arb_pkg : shared types and index helpers for the FIFO write arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Wrap an index that can exceed n-1 by less than n back into 0..n-1.
  // Kept as an explicit subtract so non-power-of-2 requester counts work.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? (idx - n) : idx;
  endfunction

  function automatic int rr_next(input int idx, input int n);
    return rr_wrap(idx + 1, n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_wr_arbiter_if : requester-side and consumer-side signals of the arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int SRC_W = $clog2(N_REQ);

  logic [N_REQ-1:0]            req_valid_i;
  logic [N_REQ-1:0]            req_ready_o;
  logic [N_REQ*DATA_WIDTH-1:0] req_data_i;
  logic                        out_valid_o;
  logic                        out_ready_i;
  logic [DATA_WIDTH-1:0]       out_data_o;
  logic [SRC_W-1:0]            out_src_o;

  modport slave (
    input  req_valid_i,
    input  req_data_i,
    input  out_ready_i,
    output req_ready_o,
    output out_valid_o,
    output out_data_o,
    output out_src_o
  );

  modport master (
    output req_valid_i,
    output req_data_i,
    output out_ready_i,
    input  req_ready_o,
    input  out_valid_o,
    input  out_data_o,
    input  out_src_o
  );

endinterface
`default_nettype wire

// File: rtl/fifo_wr_arbiter_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_wr_arbiter_fifo : synchronous FIFO, zero-latency head, registered flags
// Revision: 1.0
// ----------------------------------------------------------------------------
module fifo_wr_arbiter_fifo #(
  parameter int DEPTH_LG2  = 4,
  parameter int DATA_WIDTH = 34,
  parameter bit RST_MEM    = 1'b0
) (
  input  wire                  clk,
  input  wire                  rst_n,
  input  wire                  wr_en_i,
  input  wire [DATA_WIDTH-1:0] wr_data_i,
  input  wire                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                 full_o,
  output logic                 empty_o
);
  localparam int DEPTH = 1 << DEPTH_LG2;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH_LG2:0]    wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LG2:0]    rd_ptr_q, rd_ptr_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  w_do_wr;
  logic                  w_do_rd;

  assign w_do_wr = wr_en_i & ~full_q;
  assign w_do_rd = rd_en_i & ~empty_q;

  // Flags are derived from next-state pointers so they are registered yet exact.
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{DEPTH_LG2{1'b0}}, w_do_wr};
    rd_ptr_d = rd_ptr_q + {{DEPTH_LG2{1'b0}}, w_do_rd};
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[DEPTH_LG2] != rd_ptr_d[DEPTH_LG2]) &&
               (wr_ptr_d[DEPTH_LG2-1:0] == rd_ptr_d[DEPTH_LG2-1:0]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  if (RST_MEM) begin : g_mem_rst
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[i] <= '0;
        end
      end else if (w_do_wr) begin
        mem_q[wr_ptr_q[DEPTH_LG2-1:0]] <= wr_data_i;
      end
    end
  end else begin : g_mem_norst
    always_ff @(posedge clk) begin
      if (w_do_wr) begin
        mem_q[wr_ptr_q[DEPTH_LG2-1:0]] <= wr_data_i;
      end
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q[DEPTH_LG2-1:0]];
  assign full_o    = full_q;
  assign empty_o   = empty_q;

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_wr_arbiter : round-robin, burst-bounded sharing of one FIFO write port
// Revision: 1.0
// ----------------------------------------------------------------------------
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LG2  = 4,
  parameter int MAX_BURST  = 4
) (
  input  wire              clk,
  input  wire              rst_n,
  fifo_wr_arbiter_if.slave bus
);
  localparam int SRC_W   = $clog2(N_REQ);
  localparam int CNT_W   = $clog2(MAX_BURST + 1);
  localparam int ENTRY_W = SRC_W + DATA_WIDTH;

  arb_state_t            state_q, state_d;
  logic [SRC_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0]      owner_q, owner_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;

  logic [DATA_WIDTH-1:0] w_req_data [N_REQ];
  logic [N_REQ-1:0]      w_ready;
  logic                  w_any_valid;
  logic [SRC_W-1:0]      w_winner;
  logic                  w_owner_valid;
  logic                  w_beat_fire;
  logic                  w_last_beat;
  logic [SRC_W-1:0]      w_owner_next;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wren;
  logic                  w_rden;
  logic [ENTRY_W-1:0]    w_wdata;
  logic [ENTRY_W-1:0]    w_rdata;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign w_req_data[gi] = bus.req_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Scan from the highest offset down so the nearest valid index to rr_ptr wins.
  always_comb begin
    w_any_valid = 1'b0;
    w_winner    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid_i[SRC_W'(rr_wrap(int'(rr_ptr_q) + k, N_REQ))]) begin
        w_any_valid = 1'b1;
        w_winner    = SRC_W'(rr_wrap(int'(rr_ptr_q) + k, N_REQ));
      end
    end
  end

  assign w_owner_valid = bus.req_valid_i[owner_q];
  assign w_beat_fire   = (state_q == GRANT) & w_owner_valid & ~w_full;
  assign w_last_beat   = (beat_cnt_q == CNT_W'(MAX_BURST - 1));
  assign w_owner_next  = SRC_W'(rr_next(int'(owner_q), N_REQ));

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    w_ready    = '0;
    unique case (state_q)
      IDLE: begin
        if (w_any_valid) begin
          owner_d    = w_winner;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        w_ready[owner_q] = ~w_full;
        if (!w_owner_valid) begin
          state_d  = IDLE;
          rr_ptr_d = w_owner_next;
        end else if (w_beat_fire) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (w_last_beat) begin
            state_d  = IDLE;
            rr_ptr_d = w_owner_next;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign w_wren  = w_beat_fire;
  assign w_wdata = {owner_q, w_req_data[owner_q]};
  assign w_rden  = bus.out_valid_o & bus.out_ready_i;

  fifo_wr_arbiter_fifo #(
    .DEPTH_LG2  (DEPTH_LG2),
    .DATA_WIDTH (ENTRY_W),
    .RST_MEM    (1'b0)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (w_wren),
    .wr_data_i (w_wdata),
    .rd_en_i   (w_rden),
    .rd_data_o (w_rdata),
    .full_o    (w_full),
    .empty_o   (w_empty)
  );

  // Handshake outputs are forced low while reset is asserted, even before the first edge.
  assign bus.req_ready_o = {N_REQ{rst_n}} & w_ready;
  assign bus.out_valid_o = rst_n & ~w_empty;
  assign bus.out_data_o  = w_rdata[DATA_WIDTH-1:0];
  assign bus.out_src_o   = w_rdata[ENTRY_W-1 -: SRC_W];

`ifndef SYNTHESIS
  a_ready_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.req_ready_o))
    else $error("req_ready_o not one-hot0: %b", bus.req_ready_o);

  a_no_write_full : assert property (@(posedge clk) disable iff (!rst_n)
    !(w_wren && w_full))
    else $error("FIFO write while full");
`endif

endmodule
`default_nettype wire
